// File: rtl/instr_mem_loader_pkg.sv
// Shared types and helpers for the instruction memory loader.
// Big-endian byte ordering: byte 0 is the most significant byte.
package instr_mem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    BYTE0,
    BYTE1,
    BYTE2,
    BYTE3,
    FIN
  } state_e;

  localparam int INSTR_BYTES = 4;

  function automatic logic [7:0] be_byte(
    input logic [31:0] w,
    input logic [1:0]  idx
  );
    logic [7:0] b;
    b = w[31:24];
    case (idx)
      2'd0: b = w[31:24];
      2'd1: b = w[23:16];
      2'd2: b = w[15:8];
      2'd3: b = w[7:0];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/instr_mem_loader_mem.sv
// Byte-addressed instruction memory: synchronous write,
// combinational 4-byte big-endian read.
module instr_byte_mem
  import instr_mem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 400
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [31:0] waddr_i,
  input  logic [7:0]  wdata_i,
  input  logic [31:0] raddr_i,
  output logic [31:0] rdata_o
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0] mem_q [MEM_BYTES];

  // Write one byte per cycle; out-of-range writes are dropped.
  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i < 32'(MEM_BYTES))) begin
      mem_q[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

  // Assemble a word, lowest address into the top byte.
  always_comb begin
    logic [31:0] ra;
    ra      = '0;
    rdata_o = '0;
    for (int k = 0; k < INSTR_BYTES; k++) begin
      ra = raddr_i + 32'(k);
      if (ra < 32'(MEM_BYTES)) begin
        rdata_o[8*(3-k) +: 8] = mem_q[ra[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams 32-bit instruction words into byte memory,
// one big-endian byte write per cycle.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 400,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [31:0]      BASE_ADDR,
  input  logic [31:0]      WORD_IN,
  input  logic             WORD_VALID,
  input  logic             WORD_LAST,
  output logic             WORD_READY,
  output logic             WR_EN,
  output logic [31:0]      WR_ADDR,
  output logic [7:0]       WR_DATA,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVERFLOW,
  output logic [CNT_W-1:0] WORD_COUNT
);

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        word_q, word_d;
  logic               last_q, last_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [32:0]        end_addr;
  logic               fits;
  logic [1:0]         bidx;

  // 33-bit end address so a word near 2^32 cannot wrap.
  assign end_addr = {1'b0, addr_q} + 33'(INSTR_BYTES - 1);
  assign fits     = end_addr <= 33'(MEM_BYTES - 1);

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          addr_d  = BASE_ADDR & 32'hFFFF_FFFC;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCEPT;
        end
      end
      ACCEPT: begin
        if (WORD_VALID) begin
          word_d = WORD_IN;
          last_d = WORD_LAST;
          if (fits) begin
            state_d = BYTE0;
          end else begin
            ovf_d   = 1'b1;
            state_d = FIN;
          end
        end
      end
      BYTE0: begin
        addr_d  = addr_q + 32'd1;
        state_d = BYTE1;
      end
      BYTE1: begin
        addr_d  = addr_q + 32'd1;
        state_d = BYTE2;
      end
      BYTE2: begin
        addr_d  = addr_q + 32'd1;
        state_d = BYTE3;
      end
      BYTE3: begin
        addr_d  = addr_q + 32'd1;
        cnt_d   = (&cnt_q) ? cnt_q
                           : cnt_q + CNT_W'(1);
        state_d = last_q ? FIN : ACCEPT;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from state and registers only.
  always_comb begin
    WORD_READY = 1'b0;
    WR_EN      = 1'b0;
    DONE       = 1'b0;
    bidx       = 2'd0;
    unique case (1'b1)
      (state_q == ACCEPT): WORD_READY = 1'b1;
      (state_q == BYTE0): begin
        WR_EN = 1'b1;
        bidx  = 2'd0;
      end
      (state_q == BYTE1): begin
        WR_EN = 1'b1;
        bidx  = 2'd1;
      end
      (state_q == BYTE2): begin
        WR_EN = 1'b1;
        bidx  = 2'd2;
      end
      (state_q == BYTE3): begin
        WR_EN = 1'b1;
        bidx  = 2'd3;
      end
      (state_q == FIN): DONE = 1'b1;
      default: ;
    endcase
  end

  assign WR_DATA    = WR_EN ? be_byte(word_q, bidx)
                            : 8'h00;
  assign WR_ADDR    = addr_q;
  assign BUSY       = state_q != IDLE;
  assign OVERFLOW   = ovf_q;
  assign WORD_COUNT = cnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader
// with instr_byte_mem as the write target.
module tb_instr_mem_loader;

  localparam int MEM_BYTES = 400;
  localparam int CNT_W     = 16;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              START = 1'b0;
  logic [31:0]       BASE_ADDR = '0;
  logic [31:0]       WORD_IN = '0;
  logic              WORD_VALID = 1'b0;
  logic              WORD_LAST = 1'b0;
  logic              WORD_READY;
  logic              WR_EN;
  logic [31:0]       WR_ADDR;
  logic [7:0]        WR_DATA;
  logic              BUSY;
  logic              DONE;
  logic              OVERFLOW;
  logic [CNT_W-1:0]  WORD_COUNT;

  logic [31:0] raddr = '0;
  logic [31:0] rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [39:0] log_q [$];
  int hs_q [$];
  logic [31:0] sw [3];

  always #5 CLK = ~CLK;

  instr_mem_loader #(
    .MEM_BYTES(MEM_BYTES),
    .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .START(START),
    .BASE_ADDR(BASE_ADDR),
    .WORD_IN(WORD_IN),
    .WORD_VALID(WORD_VALID),
    .WORD_LAST(WORD_LAST),
    .WORD_READY(WORD_READY),
    .WR_EN(WR_EN),
    .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA),
    .BUSY(BUSY),
    .DONE(DONE),
    .OVERFLOW(OVERFLOW),
    .WORD_COUNT(WORD_COUNT)
  );

  instr_byte_mem #(
    .MEM_BYTES(MEM_BYTES)
  ) mem (
    .clk_i(CLK),
    .we_i(WR_EN),
    .waddr_i(WR_ADDR),
    .wdata_i(WR_DATA),
    .raddr_i(raddr),
    .rdata_o(rdata)
  );

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (WR_EN) log_q.push_back({WR_ADDR, WR_DATA});
    if (DONE) done_cnt = done_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic start(input logic [31:0] b);
    START = 1'b1;
    BASE_ADDR = b;
    tick();
    START = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w,
                           input logic last);
    int n;
    WORD_IN = w;
    WORD_LAST = last;
    WORD_VALID = 1'b1;
    n = 0;
    while (!WORD_READY && n < 50) begin
      tick();
      n++;
    end
    chk("ready_wait", 64'(WORD_READY), 64'd1);
    hs_q.push_back(cyc);
    tick();
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!DONE && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 64'(DONE), 64'd1);
    tick();
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic check_word_writes(input string tag,
                                   input int idx,
                                   input logic [31:0] a,
                                   input logic [31:0] w);
    logic [39:0] obs;
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      obs = (idx + k < log_q.size()) ? log_q[idx + k]
                                     : 40'hFF_FFFF_FFFF;
      b = 8'(w >> (24 - 8 * k));
      chk(tag, 64'(obs), 64'({a + 32'(k), b}));
    end
  endtask

  task automatic rd(input string tag,
                    input logic [31:0] a,
                    input logic [31:0] exp);
    raddr = a;
    #1;
    chk(tag, 64'(rdata), 64'(exp));
  endtask

  task automatic new_test();
    log_q.delete();
    hs_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    // reset state
    #2;
    chk("reset_outputs",
        64'({WR_EN, WORD_READY, BUSY, DONE, OVERFLOW,
             WR_DATA, WORD_COUNT, WR_ADDR}), 64'd0);
    tick();
    tick();
    RST = 1'b0;
    tick();
    chk("idle_ready", 64'({WORD_READY, BUSY}), 64'd0);

    // single word
    new_test();
    start(32'd0);
    chk("accept_ready", 64'({WORD_READY, BUSY}), 64'b11);
    send_word(32'h1234_5678, 1'b1);
    WORD_VALID = 1'b0;
    wait_done("single");
    chk("single_nwr", 64'(log_q.size()), 64'd4);
    check_word_writes("single_wr", 0, 32'd0, 32'h1234_5678);
    chk("single_cnt", 64'(WORD_COUNT), 64'd1);
    chk("single_busy", 64'(BUSY), 64'd0);
    rd("single_rd", 32'd0, 32'h1234_5678);

    // streaming three words
    new_test();
    sw[0] = 32'hA1B2_C3D4;
    sw[1] = 32'h1122_3344;
    sw[2] = 32'hCAFE_F00D;
    start(32'd8);
    chk("stream_cnt_clr", 64'(WORD_COUNT), 64'd0);
    for (int i = 0; i < 3; i++) begin
      send_word(sw[i], i == 2);
    end
    WORD_VALID = 1'b0;
    wait_done("stream");
    chk("stream_gap0", 64'(hs_q[1] - hs_q[0]), 64'd5);
    chk("stream_gap1", 64'(hs_q[2] - hs_q[1]), 64'd5);
    chk("stream_nwr", 64'(log_q.size()), 64'd12);
    for (int i = 0; i < 3; i++) begin
      check_word_writes("stream_wr", 4 * i,
                        32'd8 + 32'(4 * i), sw[i]);
    end
    chk("stream_cnt", 64'(WORD_COUNT), 64'd3);
    rd("stream_rd0", 32'd8, 32'hA1B2_C3D4);
    rd("stream_rd1", 32'd12, 32'h1122_3344);
    rd("stream_rd2", 32'd16, 32'hCAFE_F00D);

    // misaligned base
    new_test();
    start(32'd6);
    send_word(32'hDEAD_BEEF, 1'b1);
    WORD_VALID = 1'b0;
    wait_done("misal");
    chk("misal_nwr", 64'(log_q.size()), 64'd4);
    check_word_writes("misal_wr", 0, 32'd4, 32'hDEAD_BEEF);
    rd("misal_rd", 32'd4, 32'hDEAD_BEEF);

    // overflow at top of memory
    new_test();
    start(32'd396);
    send_word(32'h0102_0304, 1'b0);
    send_word(32'h5566_7788, 1'b1);
    WORD_VALID = 1'b0;
    wait_done("ovf");
    chk("ovf_nwr", 64'(log_q.size()), 64'd4);
    check_word_writes("ovf_wr", 0, 32'd396, 32'h0102_0304);
    chk("ovf_flag", 64'(OVERFLOW), 64'd1);
    chk("ovf_cnt", 64'(WORD_COUNT), 64'd1);
    rd("ovf_rd", 32'd396, 32'h0102_0304);
    tick();
    chk("ovf_sticky", 64'({OVERFLOW, BUSY}), 64'b10);

    // back-pressure and spurious START
    new_test();
    start(32'd32);
    chk("bp_ovf_clr", 64'(OVERFLOW), 64'd0);
    WORD_VALID = 1'b0;
    repeat (10) tick();
    chk("bp_stall_nwr", 64'(log_q.size()), 64'd0);
    chk("bp_stall_rdy", 64'({WORD_READY, BUSY}), 64'b11);
    send_word(32'h0BAD_F00D, 1'b1);
    WORD_VALID = 1'b0;
    tick();
    START = 1'b1;
    BASE_ADDR = 32'd100;
    tick();
    START = 1'b0;
    chk("bp_addr", 64'({WR_EN, WR_ADDR}), 64'({1'b1, 32'd34}));
    wait_done("bp");
    chk("bp_nwr", 64'(log_q.size()), 64'd4);
    check_word_writes("bp_wr", 0, 32'd32, 32'h0BAD_F00D);
    chk("bp_cnt", 64'(WORD_COUNT), 64'd1);
    rd("bp_rd", 32'd32, 32'h0BAD_F00D);

    // reset mid-word
    new_test();
    start(32'd40);
    send_word(32'hA5A5_5A5A, 1'b1);
    WORD_VALID = 1'b0;
    tick();
    tick();
    chk("rst_pre", 64'({WR_EN, WR_ADDR}), 64'({1'b1, 32'd42}));
    #1;
    RST = 1'b1;
    #1;
    chk("rst_async",
        64'({WR_EN, WORD_READY, BUSY, DONE, OVERFLOW,
             WR_DATA, WORD_COUNT, WR_ADDR}), 64'd0);
    log_q.delete();
    repeat (3) tick();
    chk("rst_nwr", 64'(log_q.size()), 64'd0);
    RST = 1'b0;
    tick();
    raddr = 32'd40;
    #1;
    chk("rst_partial", 64'(rdata[31:16]), 64'h0000_A5A5);
    new_test();
    start(32'd44);
    send_word(32'h1357_9BDF, 1'b1);
    WORD_VALID = 1'b0;
    wait_done("rst_new");
    check_word_writes("rst_new_wr", 0, 32'd44, 32'h1357_9BDF);
    chk("rst_new_cnt", 64'(WORD_COUNT), 64'd1);
    rd("rst_new_rd", 32'd44, 32'h1357_9BDF);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Writes a program image into the byte-addressed, big-endian instruction memory. It takes 32-bit instruction words over a valid/ready handshake and emits one byte write per cycle. The most significant byte goes to the lowest address. Used at boot or in test benches in place of the static file preload, and is the write-side counterpart to the combinational instruction fetch read port.

Parameters:
MEM_BYTES, 400, size of the target byte array; legal byte addresses are 0..MEM_BYTES-1
CNT_W, 16, width of the word counter

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
START  in  1  one-cycle pulse that begins a load session; ignored unless IDLE
BASE_ADDR  in  32  byte address of the first word; bits [1:0] are forced to 0 when latched
WORD_IN  in  32  instruction word to store
WORD_VALID  in  1  WORD_IN and WORD_LAST are valid
WORD_LAST  in  1  qualifies the final word of the session
WORD_READY  out  1  loader accepts a word this cycle
WR_EN  out  1  byte write strobe to the instruction memory
WR_ADDR  out  32  byte write address
WR_DATA  out  8  byte write data
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse when a session ends, normally or on overflow
OVERFLOW  out  1  sticky flag; a word would exceed MEM_BYTES-1
WORD_COUNT  out  CNT_W  number of words fully written in the current or last session

Behaviour:
- Reset is asynchronous. Every register and output goes to 0 and the state goes to IDLE. A word that is partly written when reset asserts is abandoned; no more strobes are issued.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- States: IDLE, ACCEPT, BYTE0, BYTE1, BYTE2, BYTE3, FIN.
- IDLE:
  - WORD_READY=0, WR_EN=0.
  - On START: latch addr={BASE_ADDR[31:2],2'b00}, clear WORD_COUNT, clear OVERFLOW, go to ACCEPT.
- ACCEPT:
  - WORD_READY=1.
  - A handshake is WORD_VALID&&WORD_READY on a rising edge. On a handshake, latch WORD_IN and WORD_LAST.
  - If addr+3 <= MEM_BYTES-1, go to BYTE0.
  - Otherwise set OVERFLOW, drop the word (it is consumed but not written), and go to FIN.
  - Without a handshake, stay in ACCEPT indefinitely.
- BYTE0..BYTE3:
  - WR_EN=1 and WR_ADDR=addr in each state, with addr incremented by 1 on leaving each state.
  - WR_DATA is word[31:24], [23:16], [15:8], [7:0] in BYTE0..BYTE3 respectively.
  - Leaving BYTE3: WORD_COUNT+1, which saturates at all-ones. Then go to FIN if the latched last flag is set, otherwise to ACCEPT.
- FIN: DONE=1 for exactly one cycle, then go to IDLE.
- Throughput is 5 cycles per word. Latency from the handshake edge to the first WR_EN is 1 cycle.
- START while BUSY is ignored and does not disturb the session.
- WORD_VALID while not in ACCEPT is ignored; WORD_READY=0 there.
- Address arithmetic is 32-bit. The overflow check uses 33-bit compare, so no wrap-around write can ever occur.
- OVERFLOW stays high until the next accepted START or reset. WORD_COUNT holds its value in IDLE.
- Memory-side timing: the target memory samples WR_EN/WR_ADDR/WR_DATA on the same CLK edge.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, ACCEPT, BYTE0..BYTE3, FIN);
  - a constant INSTR_BYTES=4;
  - a function for big-endian byte select: byte index 0 maps to bits [31:24].
- One natural sub-module: instr_byte_mem, a synchronous-write, combinational-read byte array of MEM_BYTES. The bench and top level use it as the loader's target, with a 4-byte big-endian read port.

Test Plan:
- Single word: START with BASE_ADDR=0, WORD_IN=32'h12345678, VALID=1, LAST=1.
  - Required: four writes 0:12, 1:34, 2:56, 3:78, then DONE pulse; WORD_COUNT=1; readback at address 0 = 32'h12345678.
- Streaming: three words with LAST on the third, BASE_ADDR=8, VALID held high.
  - Required: WORD_READY high once every 5 cycles; 12 writes at addresses 8..19; WORD_COUNT=3; exactly one DONE pulse.
- Misaligned base: BASE_ADDR=6, word 32'hDEADBEEF.
  - Required: writes at 4..7 = DE,AD,BE,EF.
- Overflow: BASE_ADDR=396, two words (LAST on the second).
  - Required: first word written to 396..399. Second word consumed with no WR_EN; OVERFLOW=1; DONE pulses; WORD_COUNT=1.
- Back-pressure and spurious inputs: VALID low for 10 cycles in ACCEPT, then high; START asserted during BYTE1.
  - Required: no writes during the stall; session unaffected by the START.
- Reset mid-word: assert RST during BYTE2.
  - Required: all outputs 0 immediately, without waiting for a clock edge; no more WR_EN; state IDLE. A new START then works normally.
